// File: rtl/bg_attribute_fetch_pkg.sv
// bg_attribute_fetch_pkg: shared constants, attribute bit fields and fetch FSM encoding.
package bg_attribute_fetch_pkg;
  localparam int TILE_COLS = 32;
  localparam int VIS_LINES = 240;
  localparam int ATTR_W = 8;
  localparam int COL_W = $clog2(TILE_COLS);
  localparam int ATTR_PAL_LSB = 0;
  localparam int ATTR_PAL_MSB = 3;
  localparam int ATTR_HFLIP = 4;
  localparam int ATTR_VFLIP = 5;
  localparam int ATTR_PRIO = 6;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;
endpackage

// File: rtl/bg_attribute_fetch_line_buffer.sv
// bg_attr_line_buffer: two-bank attribute line buffer with per-bank valid flag and fine-y tag.
module bg_attr_line_buffer
  import bg_attribute_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [ATTR_W-1:0] wr_data,
  input  logic              tag_en,
  input  logic              tag_bank,
  input  logic [2:0]        tag_fy,
  input  logic              set_valid,
  input  logic              set_bank,
  input  logic              rd_bank,
  input  logic [COL_W-1:0]  rd_col,
  output logic [ATTR_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [2:0]        rd_fy
);
  logic [ATTR_W-1:0] mem_q [2][TILE_COLS];
  logic [1:0] valid_q;
  logic [2:0] fy_q [2];
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_bank][wr_col] <= wr_data;
  // Tagging a bank for a new line always invalidates it until its fetch drains.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid_q <= '0;
      fy_q[0] <= '0;
      fy_q[1] <= '0;
    end else begin
      if (tag_en) begin
        valid_q[tag_bank] <= 1'b0;
        fy_q[tag_bank] <= tag_fy;
      end
      if (set_valid) valid_q[set_bank] <= 1'b1;
    end
  assign rd_data = mem_q[rd_bank][rd_col];
  assign rd_valid = valid_q[rd_bank];
  assign rd_fy = fy_q[rd_bank];
endmodule

// File: rtl/bg_attribute_fetch.sv
// bg_attribute_fetch: per-line attribute prefetch into a ping-pong buffer and per-pixel attribute lookup.
module bg_attribute_fetch
  import bg_attribute_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        line_start,
  input  logic [7:0]  line_y,
  output logic [4:0]  at_r_row,
  output logic [4:0]  at_r_col,
  input  logic [7:0]  at_data,
  input  logic        pix_valid,
  input  logic [7:0]  pix_x,
  output logic        attr_valid,
  output logic [7:0]  attr_out,
  output logic [2:0]  fine_x,
  output logic [2:0]  fine_y,
  output logic [4:0]  tile_col,
  output logic        fetch_busy,
  output logic        overrun
);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(TILE_COLS - 1);
  state_e state_q;
  logic fetch_bank_q, wr_v_q, overrun_q;
  logic [4:0] row_q;
  logic [COL_W-1:0] col_q, wr_col_q;
  logic attr_valid_q;
  logic [7:0] attr_q;
  logic [2:0] fine_x_q, fine_y_q;
  logic [4:0] tile_col_q;
  logic [ATTR_W-1:0] rd_data, attr_lu;
  logic rd_valid;
  logic [2:0] rd_fy;
  logic visible;
  assign visible = line_y < 8'(VIS_LINES);
  // Data returns one cycle after its address; a line_start cancels the in-flight read.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      fetch_bank_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
      wr_v_q <= 1'b0;
      wr_col_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_v_q <= state_q == FETCH && !line_start;
      wr_col_q <= col_q;
      if (line_start) begin
        fetch_bank_q <= ~fetch_bank_q;
        overrun_q <= overrun_q | (state_q != IDLE);
        state_q <= visible ? FETCH : IDLE;
        if (visible) begin
          row_q <= line_y[7:3];
          col_q <= '0;
        end
      end else if (state_q == FETCH) begin
        state_q <= col_q == LAST_COL ? DRAIN : FETCH;
        if (col_q != LAST_COL) col_q <= col_q + 1'b1;
      end else if (state_q == DRAIN) begin
        state_q <= IDLE;
      end
    end
  bg_attr_line_buffer u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_v_q),
    .wr_bank  (fetch_bank_q),
    .wr_col   (wr_col_q),
    .wr_data  (at_data),
    .tag_en   (line_start),
    .tag_bank (~fetch_bank_q),
    .tag_fy   (line_y[2:0]),
    .set_valid(state_q == DRAIN && !line_start),
    .set_bank (fetch_bank_q),
    .rd_bank  (~fetch_bank_q),
    .rd_col   (pix_x[7:3]),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_fy    (rd_fy)
  );
  assign attr_lu = rd_valid ? rd_data : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      attr_valid_q <= 1'b0;
      attr_q <= '0;
      fine_x_q <= '0;
      fine_y_q <= '0;
      tile_col_q <= '0;
    end else begin
      attr_valid_q <= pix_valid;
      if (pix_valid) begin
        attr_q <= attr_lu;
        tile_col_q <= pix_x[7:3];
        fine_x_q <= attr_lu[ATTR_HFLIP] ? ~pix_x[2:0] : pix_x[2:0];
        fine_y_q <= attr_lu[ATTR_VFLIP] ? ~rd_fy : rd_fy;
      end
    end
  assign at_r_row = row_q;
  assign at_r_col = col_q;
  assign fetch_busy = state_q != IDLE;
  assign overrun = overrun_q;
  assign attr_valid = attr_valid_q;
  assign attr_out = attr_q;
  assign fine_x = fine_x_q;
  assign fine_y = fine_y_q;
  assign tile_col = tile_col_q;
endmodule

// File: tb/tb_bg_attribute_fetch.sv
// tb_bg_attribute_fetch: directed scoreboard bench for bg_attribute_fetch.
module tb_bg_attribute_fetch;
  logic clk = 0, rst = 1, line_start = 0, pix_valid = 0;
  logic [7:0] line_y = 0, pix_x = 0, at_data = 0;
  logic [4:0] at_r_row, at_r_col, tile_col;
  logic attr_valid, fetch_busy, overrun;
  logic [7:0] attr_out;
  logic [2:0] fine_x, fine_y;
  typedef struct packed {logic [7:0] a; logic [2:0] fx; logic [2:0] fy; logic [4:0] tc;} exp_t;
  exp_t q[$];
  exp_t hold = '0;
  logic pv_seen;
  logic mon_en = 0;
  int n_chk = 0, n_pass = 0;
  logic [7:0] tbl [32][32];
  always #5 clk = ~clk;
  bg_attribute_fetch dut (
    .clk(clk), .rst(rst), .line_start(line_start), .line_y(line_y),
    .at_r_row(at_r_row), .at_r_col(at_r_col), .at_data(at_data),
    .pix_valid(pix_valid), .pix_x(pix_x), .attr_valid(attr_valid), .attr_out(attr_out),
    .fine_x(fine_x), .fine_y(fine_y), .tile_col(tile_col),
    .fetch_busy(fetch_busy), .overrun(overrun)
  );
  always @(posedge clk) at_data <= tbl[at_r_row][at_r_col];
  always @(posedge clk or negedge rst)
    if (!rst) pv_seen <= 1'b0;
    else pv_seen <= pix_valid;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s got %0h want %0h", tag, act, exp);
  endtask
  function automatic exp_t mk(input logic [7:0] x, input logic [7:0] a, input logic [2:0] dy);
    exp_t e;
    e.a = a;
    e.tc = x[7:3];
    e.fx = a[4] ? ~x[2:0] : x[2:0];
    e.fy = a[5] ? ~dy : dy;
    return e;
  endfunction
  task automatic pix(input logic [7:0] x, input logic [7:0] a, input logic [2:0] dy);
    @(posedge clk); #1 pix_valid = 1; pix_x = x;
    q.push_back(mk(x, a, dy));
  endtask
  task automatic pix_end;
    @(posedge clk); #1 pix_valid = 0;
  endtask
  task automatic ls(input logic [7:0] y);
    @(posedge clk); #1 line_start = 1; line_y = y;
    @(posedge clk); #1 line_start = 0;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string p);
    check({p, "_attr_valid"}, 32'(attr_valid), 32'd0);
    check({p, "_attr_out"}, 32'(attr_out), 32'd0);
    check({p, "_fine_x"}, 32'(fine_x), 32'd0);
    check({p, "_fine_y"}, 32'(fine_y), 32'd0);
    check({p, "_tile_col"}, 32'(tile_col), 32'd0);
    check({p, "_fetch_busy"}, 32'(fetch_busy), 32'd0);
    check({p, "_overrun"}, 32'(overrun), 32'd0);
    check({p, "_at_r_row"}, 32'(at_r_row), 32'd0);
    check({p, "_at_r_col"}, 32'(at_r_col), 32'd0);
  endtask
  // Pixel outputs follow the scoreboard on a valid cycle and hold otherwise.
  always @(negedge clk)
    if (!rst) hold = '0;
    else if (mon_en) begin
      check("attr_valid", 32'(attr_valid), 32'(pv_seen));
      if (pv_seen) begin
        if (q.size() == 0) check("sb_empty", 32'(q.size()), 32'd1);
        else hold = q.pop_front();
      end
      check("attr_out", 32'(attr_out), 32'(hold.a));
      check("tile_col", 32'(tile_col), 32'(hold.tc));
      check("fine_x", 32'(fine_x), 32'(hold.fx));
      check("fine_y", 32'(fine_y), 32'(hold.fy));
    end
  initial begin
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) tbl[r][c] = {3'(r), 5'(c)};
    #2 rst = 0;
    #1 chk_zero("reset");
    cyc(2);
    rst = 1;
    mon_en = 1;
    ls(8'd17);
    check("t1_busy", 32'(fetch_busy), 32'd1);
    check("t1_row", 32'(at_r_row), 32'd2);
    check("t1_col0", 32'(at_r_col), 32'd0);
    cyc(5);
    check("t1_col5", 32'(at_r_col), 32'd5);
    cyc(28);
    check("t1_done", 32'(fetch_busy), 32'd0);
    check("t1_col_hold", 32'(at_r_col), 32'd31);
    ls(8'd18);
    for (int x = 0; x < 256; x++) pix(8'(x), {3'd2, 5'(x >> 3)}, 3'd1);
    pix_end;
    tbl[0][0] = 8'h10;
    tbl[1][0] = 8'h20;
    ls(8'd0);
    cyc(33);
    ls(8'd10);
    pix(8'd3, 8'h10, 3'd0);
    @(negedge clk);
    check("t2_lat_early", 32'(attr_valid), 32'd0);
    pix_end;
    check("t2_lat", 32'(attr_valid), 32'd1);
    check("t2_fine_x", 32'(fine_x), 32'd4);
    cyc(1);
    check("t2_lat_drop", 32'(attr_valid), 32'd0);
    pix(8'd9, 8'h01, 3'd0);
    pix_end;
    cyc(33);
    ls(8'd20);
    pix(8'd0, 8'h20, 3'd2);
    pix_end;
    check("t3_fine_y", 32'(fine_y), 32'd5);
    cyc(4);
    check("t4_no_overrun", 32'(overrun), 32'd0);
    ls(8'd21);
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_restart_col", 32'(at_r_col), 32'd0);
    check("t4_busy", 32'(fetch_busy), 32'd1);
    cyc(2);
    check("t4_col2", 32'(at_r_col), 32'd2);
    for (int x = 0; x < 256; x += 3) pix(8'(x), 8'h00, 3'd4);
    pix_end;
    cyc(33);
    ls(8'd245);
    check("t5_busy", 32'(fetch_busy), 32'd0);
    check("t5_col_hold", 32'(at_r_col), 32'd31);
    check("t5_row_hold", 32'(at_r_row), 32'd2);
    cyc(5);
    check("t5_busy_later", 32'(fetch_busy), 32'd0);
    check("t5_col_later", 32'(at_r_col), 32'd31);
    pix(8'd8, 8'h41, 3'd5);
    pix_end;
    ls(8'd50);
    for (int x = 0; x < 256; x += 37) pix(8'(x), 8'h00, 3'd5);
    pix_end;
    cyc(33);
    ls(8'd60);
    cyc(12);
    check("t6_col12", 32'(at_r_col), 32'd12);
    rst = 0;
    #1 chk_zero("t6_rst");
    cyc(2);
    rst = 1;
    for (int x = 0; x < 256; x += 29) pix(8'(x), 8'h00, 3'd0);
    pix_end;
    ls(8'd61);
    for (int x = 0; x < 256; x += 41) pix(8'(x), 8'h00, 3'd0);
    pix_end;
    cyc(33);
    ls(8'd62);
    for (int x = 0; x < 256; x += 9) pix(8'(x), {3'd7, 5'(x >> 3)}, 3'd5);
    pix_end;
    cyc(2);
    check("sb_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
